// File: rtl/controle_banco.sv
// Sequencer for a single-port register bank: turns one LOAD/MOVE/READ/SWAP
// command into a series of bank cycles, one read or one write per cycle.
module controle_banco #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    rx,
    input  logic [AW-1:0]    ry,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] bank_in,
    output logic [AW-1:0]    bank_key,
    output logic             bank_w,
    input  logic [WIDTH-1:0] bank_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_Y,
        RD_X,
        WR_X,
        WR_Y,
        DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    state_t             state, state_nx;
    logic [1:0]         op_q;
    logic [AW-1:0]      rx_q, ry_q;
    logic [WIDTH-1:0]   imm_q, tmp_x, tmp_y;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= OP_LOAD;
            rx_q  <= '0;
            ry_q  <= '0;
            imm_q <= '0;
            tmp_x <= '0;
            tmp_y <= '0;
            dout  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op_q  <= op;
                rx_q  <= rx;
                ry_q  <= ry;
                imm_q <= imm;
            end
            if (state == RD_Y) begin
                tmp_y <= bank_out;
                if (op_q == OP_READ)
                    dout <= bank_out;
            end
            if (state == RD_X)
                tmp_x <= bank_out;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        bank_w   = 1'b0;
        bank_key = '0;
        bank_in  = '0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = (op == OP_LOAD) ? WR_X : RD_Y;
            end
            RD_Y: begin
                busy     = 1'b1;
                bank_key = ry_q;
                case (op_q)
                    OP_READ: state_nx = DONE;
                    OP_SWAP: state_nx = RD_X;
                    default: state_nx = WR_X;
                endcase
            end
            RD_X: begin
                busy     = 1'b1;
                bank_key = rx_q;
                state_nx = WR_X;
            end
            WR_X: begin
                busy     = 1'b1;
                bank_w   = 1'b1;
                bank_key = rx_q;
                bank_in  = (op_q == OP_LOAD) ? imm_q : tmp_y;
                state_nx = (op_q == OP_SWAP) ? WR_Y : DONE;
            end
            WR_Y: begin
                busy     = 1'b1;
                bank_w   = 1'b1;
                bank_key = ry_q;
                bank_in  = tmp_x;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_controle_banco.sv
// Self-checking bench for controle_banco: a bank array, a command-level
// reference model, a per-cycle compare process and directed scenarios.
module tb_controle_banco;

    localparam int WIDTH = 16;
    localparam int AW    = 3;
    localparam int NREG  = 1 << AW;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op    = 2'b00;
    logic [AW-1:0]    rx    = '0;
    logic [AW-1:0]    ry    = '0;
    logic [WIDTH-1:0] imm   = '0;
    logic             busy, done, bank_w;
    logic [WIDTH-1:0] dout, bank_in, bank_out;
    logic [AW-1:0]    bank_key;

    logic [WIDTH-1:0] mem [NREG];

    int n_cmp = 0;
    int n_err = 0;

    controle_banco #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rx       (rx),
        .ry       (ry),
        .imm      (imm),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .bank_in  (bank_in),
        .bank_key (bank_key),
        .bank_w   (bank_w),
        .bank_out (bank_out)
    );

    always #5 clock = ~clock;

    // The bank itself: combinational read, synchronous write, never reset.
    assign bank_out = mem[bank_key];
    always @(posedge clock)
        if (bank_w) mem[bank_key] <= bank_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        case (o)
            OP_LOAD: return 2;
            OP_READ: return 2;
            OP_MOVE: return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int writes_of(input logic [1:0] o);
        case (o)
            OP_LOAD: return 1;
            OP_READ: return 0;
            OP_MOVE: return 1;
            default: return 2;
        endcase
    endfunction

    // Command-level model: k counts edges since acceptance (0 = idle).
    logic [WIDTH-1:0] ref_mem  [NREG];
    logic [WIDTH-1:0] snap_mem [NREG];
    logic [WIDTH-1:0] ref_dout = '0;
    logic [WIDTH-1:0] tmp;
    int k = 0, lat = 0, wr_exp = 0, wr_seen = 0;
    logic [AW-1:0]    last_key;
    logic [WIDTH-1:0] last_in;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            if (k != 0) snap_to_ref();
            k = 0;
            ref_dout = '0;
        end else if (k == 0) begin
            if (start) begin
                snap_mem = ref_mem;
                lat      = lat_of(op);
                wr_exp   = writes_of(op);
                wr_seen  = 0;
                case (op)
                    OP_LOAD: ref_mem[rx] = imm;
                    OP_MOVE: ref_mem[rx] = ref_mem[ry];
                    OP_READ: ref_dout = ref_mem[ry];
                    default: begin
                        tmp         = ref_mem[rx];
                        ref_mem[rx] = ref_mem[ry];
                        ref_mem[ry] = tmp;
                    end
                endcase
                k = 1;
            end
        end else if (k == lat) begin
            k = 0;
        end else begin
            k++;
        end
    end

    task automatic snap_to_ref();
        ref_mem = snap_mem;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            check("busy", 32'(busy), 32'(k >= 1 && k < lat));
            check("done", 32'(done), 32'(k != 0 && k == lat));
            if (k == 0 || k == lat) begin
                check("dout", 32'(dout), 32'(ref_dout));
                check("bank_w_quiet", 32'(bank_w), 32'(0));
                check("bank_key_quiet", 32'(bank_key), 32'(0));
                check("bank_in_quiet", 32'(bank_in), 32'(0));
            end
            if (bank_w) begin
                wr_seen++;
                last_key = bank_key;
                last_in  = bank_in;
            end
            if (k != 0 && k == lat) begin
                check("write_count", 32'(wr_seen), 32'(wr_exp));
                for (int i = 0; i < NREG; i++)
                    check($sformatf("bank_r%0d", i), 32'(mem[i]), 32'(ref_mem[i]));
            end
        end
    end

    // Issue one command from IDLE and return the edge count to done.
    task automatic run_cmd(input logic [1:0] o, input logic [AW-1:0] x,
                           input logic [AW-1:0] y, input logic [WIDTH-1:0] v,
                           output int n);
        @(posedge clock); #1;
        start = 1'b1; op = o; rx = x; ry = y; imm = v;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("done_seen", 32'(done), 32'(1));
    endtask

    int n, n2;

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_bank_w", 32'(bank_w), 32'(0));
        reset = 1'b0;

        // LOAD then READ back
        run_cmd(OP_LOAD, 3'd3, 3'd0, 16'hBEEF, n);
        check("load_latency", 32'(n), 32'd2);
        check("load_key", 32'(last_key), 32'd3);
        check("load_in", 32'(last_in), 32'hBEEF);
        run_cmd(OP_READ, 3'd0, 3'd3, 16'h0000, n);
        check("read_latency", 32'(n), 32'd2);
        check("read_dout", 32'(dout), 32'hBEEF);

        // MOVE R6 <- R1
        run_cmd(OP_LOAD, 3'd1, 3'd0, 16'h1111, n);
        run_cmd(OP_LOAD, 3'd6, 3'd0, 16'h6666, n);
        run_cmd(OP_MOVE, 3'd6, 3'd1, 16'h0000, n);
        check("move_latency", 32'(n), 32'd3);
        check("move_r6", 32'(mem[6]), 32'h1111);
        check("move_r1", 32'(mem[1]), 32'h1111);

        // SWAP aborted by reset while in WR_X
        run_cmd(OP_LOAD, 3'd2, 3'd0, 16'hAAAA, n);
        run_cmd(OP_LOAD, 3'd5, 3'd0, 16'h5555, n);
        @(posedge clock); #1;
        start = 1'b1; op = OP_SWAP; rx = 3'd2; ry = 3'd5;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("wrx_bank_w", 32'(bank_w), 32'(1));
        check("wrx_bank_key", 32'(bank_key), 32'd2);
        reset = 1'b1;
        #1;
        check("abort_bank_w", 32'(bank_w), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_dout", 32'(dout), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_r5", 32'(mem[5]), 32'h5555);
        check("abort_r2", 32'(mem[2]), 32'hAAAA);

        // Full SWAP after the abort
        run_cmd(OP_SWAP, 3'd2, 3'd5, 16'h0000, n);
        check("swap_latency", 32'(n), 32'd5);
        check("swap_r2", 32'(mem[2]), 32'h5555);
        check("swap_r5", 32'(mem[5]), 32'hAAAA);

        // start held high; inputs change mid-command
        run_cmd(OP_LOAD, 3'd7, 3'd0, 16'h7777, n);
        @(posedge clock); #1;
        start = 1'b1; op = OP_MOVE; rx = 3'd7; ry = 3'd3; imm = 16'h0000;
        @(posedge clock); #1;
        op = OP_LOAD; rx = 3'd0; imm = 16'h1234;
        n = 1;
        while (!done && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("held_move_latency", 32'(n), 32'd3);
        n2 = 0;
        do begin
            @(posedge clock); #1;
            n2++;
        end while (!done && n2 < 20);
        start = 1'b0;
        check("held_next_done", 32'(n2), 32'd3);
        check("held_r7", 32'(mem[7]), 32'hBEEF);
        check("held_r0", 32'(mem[0]), 32'h1234);

        // SWAP of a register with itself
        run_cmd(OP_LOAD, 3'd4, 3'd0, 16'h0F0F, n);
        run_cmd(OP_SWAP, 3'd4, 3'd4, 16'h0000, n);
        check("self_swap_latency", 32'(n), 32'd5);
        check("self_swap_r4", 32'(mem[4]), 32'h0F0F);

        run_cmd(OP_READ, 3'd0, 3'd5, 16'h0000, n);
        check("final_dout", 32'(dout), 32'hAAAA);
        repeat (3) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
